ads127l01_tx: RTL and testbench



---
 rtl/ads127l01_tx_if.sv | 22 ++
 rtl/ads127l01_tx.sv | 139 +++++++++++++
 tb/tb_ads127l01_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ads127l01_tx_if.sv
// Sample-in / serial-out bundle for the ADS127L01-style frame transmitter.
// slave is the transmitter side; master is the upstream source and serial sink side.
interface ads127l01_tx_if;
  logic        en;
  logic [23:0] data_in;
  logic        valid_in;
  logic        ready;
  logic        sck;
  logic        dout;
  logic        fsync;
  logic        busy;

  modport master (
    output en, data_in, valid_in,
    input  ready, sck, dout, fsync, busy
  );

  modport slave (
    input  en, data_in, valid_in,
    output ready, sck, dout, fsync, busy
  );
endinterface

// File: rtl/ads127l01_tx.sv
// Serialises a 24-bit sample plus pad byte as a 32-bit MSB-first frame, followed by an fsync strobe.
// Define ADS127L01_TX_FRAME_CNT_EN to carry a wrapping frame counter in the pad byte (otherwise 8'h00).
module ads127l01_tx #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned PAD_BITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  ads127l01_tx_if.slave bus
);

  localparam int unsigned         FRAME_BITS = 24 + PAD_BITS;
  localparam logic [7:0]          HALF_LAST  = 8'(DIV - 1);
  localparam logic [4:0]          BIT_LAST   = 5'(FRAME_BITS - 1);
  localparam logic [PAD_BITS-1:0] PAD_ONE    = PAD_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SYNC  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [7:0]            hcnt, hcnt_n;
  logic [4:0]            bcnt, bcnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic                  sck_q, sck_n;
  logic                  fsync_q, fsync_n;
  logic                  busy_q, busy_n;
  logic [PAD_BITS-1:0]   pad;
  logic                  accept;

  assign bus.ready = (state == IDLE) && bus.en && !rst;
  assign accept    = bus.valid_in && bus.ready;

`ifdef ADS127L01_TX_FRAME_CNT_EN
  logic [PAD_BITS-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (accept) begin
      frame_cnt <= frame_cnt + PAD_ONE;
    end
  end

  assign pad = frame_cnt;
`else
  assign pad = '0;
`endif

  // The frame's final shift empties the register, so dout is zero in SYNC and IDLE
  // without a separate output mux.
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    sck_n   = sck_q;
    fsync_n = fsync_q;
    busy_n  = busy_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = {bus.data_in, pad};
          hcnt_n  = '0;
          bcnt_n  = '0;
          sck_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt != HALF_LAST) begin
          hcnt_n = hcnt + 8'd1;
        end else begin
          hcnt_n = '0;
          sck_n  = ~sck_q;
          if (sck_q) begin
            shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
            if (bcnt == BIT_LAST) begin
              state_n = SYNC;
              bcnt_n  = '0;
              sck_n   = 1'b0;
              fsync_n = 1'b1;
            end else begin
              bcnt_n = bcnt + 5'd1;
            end
          end
        end
      end
      SYNC: begin
        // bcnt[0] tracks which half of the two-half-period strobe is running
        if (hcnt != HALF_LAST) begin
          hcnt_n = hcnt + 8'd1;
        end else begin
          hcnt_n = '0;
          if (bcnt[0]) begin
            state_n = IDLE;
            bcnt_n  = '0;
            fsync_n = 1'b0;
            busy_n  = 1'b0;
          end else begin
            bcnt_n = 5'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      sck_q   <= 1'b0;
      fsync_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      bcnt    <= bcnt_n;
      shreg   <= shreg_n;
      sck_q   <= sck_n;
      fsync_q <= fsync_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.sck   = sck_q;
  assign bus.dout  = shreg[FRAME_BITS-1];
  assign bus.fsync = fsync_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ads127l01_tx.sv
// Scoreboard bench for ads127l01_tx: two instances (DIV=2 as index 0, DIV=1 as index 1),
// expected frames queued at accept time and checked by a negedge monitor at each fsync.
module tb_ads127l01_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  typedef struct {
    logic [31:0] word;
    int unsigned fs_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [7:0]  fcnt [2];
  logic        prev_sck [2];
  logic        prev_fs [2];
  logic [31:0] acc [2];
  int unsigned nbits [2];
  int unsigned fs_len [2];
  int unsigned rises [2];
  int unsigned quiet_bad [2];

  ads127l01_tx_if bus_a ();
  ads127l01_tx_if bus_b ();

  ads127l01_tx #(.DIV(2), .PAD_BITS(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  ads127l01_tx #(.DIV(1), .PAD_BITS(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic int unsigned div_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon(input int d, input logic sck, input logic dout, input logic fsync,
                     input logic busy);
    exp_t e;
    bit   empty;
    if (busy === 1'b0) begin
      acc[d]   = '0;
      nbits[d] = 0;
      if (sck || dout || fsync) quiet_bad[d]++;
    end
    if (fsync === 1'b1 && (sck || dout)) quiet_bad[d]++;
    if (sck === 1'b1 && prev_sck[d] === 1'b0) begin
      acc[d] = {acc[d][30:0], dout};
      nbits[d]++;
      rises[d]++;
    end
    if (fsync === 1'b1 && prev_fs[d] === 1'b0) begin
      empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      if (empty) begin
        check($sformatf("dut%0d_unexpected_fsync", d), 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        check($sformatf("dut%0d_frame_word", d), acc[d], e.word);
        check($sformatf("dut%0d_fsync_cycle", d), cyc, e.fs_cyc);
        check($sformatf("dut%0d_bit_count", d), nbits[d], 32);
      end
    end
    if (fsync === 1'b1) begin
      fs_len[d]++;
    end else if (prev_fs[d] === 1'b1) begin
      check($sformatf("dut%0d_fsync_len", d), fs_len[d], 2 * div_of(d));
      fs_len[d] = 0;
    end
    prev_sck[d] = sck;
    prev_fs[d]  = fsync;
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.sck, bus_a.dout, bus_a.fsync, bus_a.busy);
    mon(1, bus_b.sck, bus_b.dout, bus_b.fsync, bus_b.busy);
  end

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic flush_model();
    q_a.delete();
    q_b.delete();
    fcnt[0] = 8'h00;
    fcnt[1] = 8'h00;
  endtask

  task automatic check_idle(input int d, input logic exp_ready, input string tag);
    if (d == 0) begin
      check({tag, "_sck"},   bus_a.sck,   0);
      check({tag, "_dout"},  bus_a.dout,  0);
      check({tag, "_fsync"}, bus_a.fsync, 0);
      check({tag, "_busy"},  bus_a.busy,  0);
      check({tag, "_ready"}, bus_a.ready, exp_ready);
    end else begin
      check({tag, "_sck"},   bus_b.sck,   0);
      check({tag, "_dout"},  bus_b.dout,  0);
      check({tag, "_fsync"}, bus_b.fsync, 0);
      check({tag, "_busy"},  bus_b.busy,  0);
      check({tag, "_ready"}, bus_b.ready, exp_ready);
    end
  endtask

  // Presents a sample and waits for it to be accepted; t is the accept cycle.
  task automatic send(input int d, input logic [23:0] data, input bit hold,
                      output int unsigned t);
    bit         ok;
    logic       rdy;
    logic [7:0] pad;
    exp_t       e;
    ok = 1'b0;
    t  = 0;
    if (d == 0) begin bus_a.data_in = data; bus_a.valid_in = 1'b1; end
    else        begin bus_b.data_in = data; bus_b.valid_in = 1'b1; end
    for (int i = 0; i < 3000 && !ok; i++) begin
      #1;
      rdy = (d == 0) ? bus_a.ready : bus_b.ready;
      if (rdy === 1'b1) begin
        t  = cyc;
        ok = 1'b1;
`ifdef ADS127L01_TX_FRAME_CNT_EN
        pad     = fcnt[d];
        fcnt[d] = fcnt[d] + 8'd1;
`else
        pad = 8'h00;
`endif
        e.word   = {data, pad};
        e.fs_cyc = t + 64 * div_of(d) + 1;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
      @(negedge clk);
    end
    if (!hold) begin
      if (d == 0) bus_a.valid_in = 1'b0;
      else        bus_b.valid_in = 1'b0;
    end
    if (!ok) check($sformatf("dut%0d_accept_timeout", d), 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned t, t1, t2, r0;
    for (int i = 0; i < 2; i++) begin
      fcnt[i] = 8'h00; acc[i] = '0; nbits[i] = 0; fs_len[i] = 0;
      rises[i] = 0; quiet_bad[i] = 0; prev_sck[i] = 1'b0; prev_fs[i] = 1'b0;
    end
    bus_a.en = 1'b1; bus_a.valid_in = 1'b0; bus_a.data_in = '0;
    bus_b.en = 1'b1; bus_b.valid_in = 1'b0; bus_b.data_in = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle(0, 1'b0, "reset_a");
    check_idle(1, 1'b0, "reset_b");
    rst = 1'b0;
    #1;
    check("ready_after_reset_a", bus_a.ready, 1);
    @(negedge clk);

    // Single frame, DIV=2: fsync T+129..T+132, ready again at T+133
    send(0, 24'hA55AC3, 1'b0, t);
    wait_until(t + 132);
    check("ready_low_in_sync", bus_a.ready, 0);
    check("busy_high_in_sync", bus_a.busy, 1);
    wait_until(t + 133);
    check("ready_back_at_133", bus_a.ready, 1);
    check("busy_low_at_133", bus_a.busy, 0);

    // Back-to-back frames with valid_in held high
    r0 = rises[0];
    send(0, 24'h000001, 1'b1, t1);
    send(0, 24'hFFFFFF, 1'b0, t2);
    check("b2b_accept_gap", t2 - t1, 133);
    wait_until(t2 + 133);
    check("b2b_sck_rises", rises[0] - r0, 64);

    // Reset mid-frame aborts it with no fsync; the next frame is clean
    send(0, 24'h123456, 1'b0, t);
    wait_until(t + 40);
    rst = 1'b1;
    flush_model();
    @(negedge clk);
    check_idle(0, 1'b0, "abort_a");
    rst = 1'b0;
    #1;
    check("ready_after_abort", bus_a.ready, 1);
    @(negedge clk);
    send(0, 24'h5A0F3C, 1'b0, t);
    wait_until(t + 140);

    // en dropped mid-frame: frame completes, then no accept until en returns
    send(0, 24'h0F0F0F, 1'b0, t);
    wait_until(t + 10);
    bus_a.en = 1'b0;
    wait_until(t + 140);
    bus_a.data_in  = 24'h3C3C3C;
    bus_a.valid_in = 1'b1;
    #1;
    check("ready_low_en_off", bus_a.ready, 0);
    repeat (5) @(negedge clk);
    check("no_accept_en_off", bus_a.busy, 0);
    bus_a.en = 1'b1;
    send(0, 24'h3C3C3C, 1'b0, t);
    wait_until(t + 140);

    // DIV=1, single MSB set
    send(1, 24'h800000, 1'b0, t);
    wait_until(t + 70);

    // 257 back-to-back frames from reset: pad byte wraps when the counter is built in
    rst = 1'b1;
    flush_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      logic [23:0] d;
      d = 24'(i * 32'h00013579) ^ 24'hC0FFEE;
      send(1, d, (i != 256), t);
    end
    wait_until(t + 70);

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    check("quiet_a", quiet_bad[0], 0);
    check("quiet_b", quiet_bad[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
